rram_verify_sequencer: RTL and testbench
========================================

# rram_verify_sequencer

Program-and-verify sequencer between the command `control` unit and the RRAM array write/read driver. It accepts one forming, write or read request at a time. It drives the driver strobes (`forming_writeread`, `we_writeread`, `re_writeread`) in an iterative pulse → settle → verify-read loop, stepping the pulse amplitude code until the cell reads back correctly or the retry budget is exhausted. Completion, pass/fail and ready/busy (`RB`) are reported back to the controller.

## Interface
- `ADDR_W`, 8, array address width
- `DATA_W`, 8, array word width
- `MAX_PULSES`, 8, maximum program pulses per forming/write op (1..15)
- `PULSE_CYC`, 4, cycles a forming/write strobe is held high (≥1)
- `SETTLE_CYC`, 2, idle cycles between pulse end and verify read (≥1)
- `READ_CYC`, 2, cycles `re_writeread` is held for any read (≥1)
- `VF_START`, 4'd8, initial amplitude code for forming
- `VW_START`, 4'd2, initial amplitude code for write
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `op` in 2: operation select. 00 = forming, 01 = write, 10 = read, 11 = reserved.
- `addr` in ADDR_W: target address, latched on an accepted `start`.
- `wdata` in DATA_W: write data, latched on an accepted `start`.
- `arr_rdata` in DATA_W: sense-amp output, valid in the last `READ_CYC` cycle.
- `forming_writeread` out 1: forming pulse strobe.
- `we_writeread` out 1: write pulse strobe.
- `re_writeread` out 1: read strobe.
- `arr_addr` out ADDR_W: registered address to the array.
- `arr_wdata` out DATA_W: registered write data (forming drives all ones).
- `v_code` out 4: pulse amplitude code.
- `pulse_cnt` out 4: pulses issued in the current/last op.
- `rdata` out DATA_W: read result, updated on read completion.
- `done` out 1: one-cycle completion pulse.
- `fail` out 1: valid with `done`; 1 = verify failed after MAX_PULSES.
- `RB` out 1: 1 = ready (IDLE), 0 = busy.

## Operation
- States: IDLE, PULSE, SETTLE, VERIFY, CHECK, READ, FINISH.
- IDLE: `RB`=1.
  - `start`=1 with `op`=00/01: latch `addr`, `wdata` and `op`; `pulse_cnt`←0; `v_code`←VF_START (forming) or VW_START (write); go to PULSE.
  - `start`=1 with `op`=10: latch `addr`; go to READ.
  - `op`=11: accepted as a no-op. Go to FINISH with `fail`=1.
- PULSE: hold `forming_writeread` (op 00) or `we_writeread` (op 01) high for exactly PULSE_CYC cycles. On entry, `pulse_cnt` increments by 1. Then go to SETTLE.
- SETTLE: all strobes low for SETTLE_CYC cycles, then go to VERIFY.
- VERIFY: `re_writeread` high for READ_CYC cycles. Capture `arr_rdata` on the last cycle, then go to CHECK.
- CHECK (1 cycle), pass criterion:
  - Forming passes if the captured data is all ones.
  - Write passes if the captured data equals the latched `wdata`.
  - Pass: go to FINISH with `fail`=0.
  - Not pass and `pulse_cnt`==MAX_PULSES: go to FINISH with `fail`=1.
  - Otherwise `v_code`←`v_code`+1, saturating at 4'hF, and go to PULSE.
- READ: `re_writeread` high for READ_CYC cycles. `rdata`←`arr_rdata` on the last cycle. Go to FINISH with `fail`=0. A read does not change `pulse_cnt` or `v_code`.
- FINISH (1 cycle): `done`=1, `fail` valid, `RB` still 0. Next state is IDLE.
- Hold rules:
  - `start` outside IDLE is ignored; requests are not queued.
  - Input changes on `addr`/`wdata` after acceptance have no effect.
- At most one strobe is high in any cycle.

## Timing
- Reset values: state IDLE; `forming_writeread`, `we_writeread`, `re_writeread`, `done`, `fail` = 0; `RB`=1; `arr_addr`, `arr_wdata`, `rdata`, `pulse_cnt`, `v_code` = 0.
- `rst` during any state: on the next edge all strobes are low, `RB`=1, state is IDLE, and no `done` is generated.
- `RB` falls on the edge after `start` is accepted and rises on the edge after FINISH.
- `arr_addr` and `arr_wdata` are valid from the first PULSE/READ cycle and stable until IDLE.
- Latency from `start` edge to `done` high:
  - Read: READ_CYC+1 cycles.
  - Program op passing on pulse N: N·(PULSE_CYC+SETTLE_CYC+READ_CYC+1)+1 cycles.
- Back-to-back: a `start` in the first IDLE cycle after FINISH is accepted.

## Test plan
- Reset: `rst`=1 for 2 cycles → all outputs at the reset values above and `RB`=1.
- Read: `op`=10, `addr`=8'h3C, `arr_rdata`=8'hA5 → `re_writeread` high for 2 cycles, `rdata`=8'hA5, `done` 3 cycles after `start`, `fail`=0, `pulse_cnt`=0.
- Forming passes on the 3rd pulse (array model returns all ones only after 3 pulses) → 3 forming pulses of 4 cycles each, `v_code` takes 8, 9, 10, `pulse_cnt`=3, `fail`=0, `done` at cycle 28.
- Write never verifies (`wdata`=8'h5A, array returns 8'h00) → exactly 8 `we_writeread` pulses, `v_code` ends at 9, `fail`=1 with `done`.
- Reset mid-PULSE → strobe drops on the next edge, no `done`, and a fresh read starts normally.
- `start` pulsed while busy, and `op`=11 → busy `start` is ignored with the ongoing op unaffected; `op`=11 gives `done` with `fail`=1 and no strobes.

Source files
------------

// File: rtl/rram_verify_sequencer.sv
// Program-and-verify sequencer for the RRAM array driver.
// It runs one forming, write or read request at a time. Program ops loop
// through pulse -> settle -> verify-read, and the amplitude code steps up on
// every retry. Strobes, address and data are registered in phase with the
// state. done/fail/RB are a registered view of the state, one cycle behind it.
module rram_verify_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 8,
    parameter int          MAX_PULSES = 8,
    parameter int          PULSE_CYC  = 4,
    parameter int          SETTLE_CYC = 2,
    parameter int          READ_CYC   = 2,
    parameter logic [3:0]  VF_START   = 4'd8,
    parameter logic [3:0]  VW_START   = 4'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] arr_rdata,
    output logic              forming_writeread,
    output logic              we_writeread,
    output logic              re_writeread,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W-1:0] arr_wdata,
    output logic [3:0]        v_code,
    output logic [3:0]        pulse_cnt,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              fail,
    output logic              RB
);

    typedef enum logic [2:0] {IDLE, PULSE, SETTLE, VERIFY, CHECK, READ, FINISH} state_t;

    state_t            state;
    logic [7:0]        cnt;       // cycles spent in the current timed state
    logic              is_form;   // latched op: 1 = forming, 0 = write
    logic              fail_q;    // verdict that is carried into FINISH
    logic [DATA_W-1:0] cap;       // verify-read capture
    logic              pass;

    // For forming, arr_wdata holds all ones, so a single compare covers both program ops.
    assign pass = (cap == arr_wdata);

    // Sequencer FSM with registered strobes and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            is_form           <= 1'b0;
            fail_q            <= 1'b0;
            cap               <= '0;
            forming_writeread <= 1'b0;
            we_writeread      <= 1'b0;
            re_writeread      <= 1'b0;
            arr_addr          <= '0;
            arr_wdata         <= '0;
            v_code            <= '0;
            pulse_cnt         <= '0;
            rdata             <= '0;
            done              <= 1'b0;
            fail              <= 1'b0;
            RB                <= 1'b1;
        end else begin
            done <= (state == FINISH);
            fail <= (state == FINISH) && fail_q;
            RB   <= (state == IDLE);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        case (op)
                            2'b00, 2'b01: begin
                                is_form           <= (op == 2'b00);
                                arr_addr          <= addr;
                                arr_wdata         <= (op == 2'b00) ? '1 : wdata;
                                v_code            <= (op == 2'b00) ? VF_START : VW_START;
                                pulse_cnt         <= 4'd1;
                                forming_writeread <= (op == 2'b00);
                                we_writeread      <= (op == 2'b01);
                                state             <= PULSE;
                            end
                            2'b10: begin
                                arr_addr     <= addr;
                                re_writeread <= 1'b1;
                                state        <= READ;
                            end
                            default: begin
                                fail_q <= 1'b1;
                                state  <= FINISH;
                            end
                        endcase
                    end
                end
                PULSE: begin
                    if (cnt == 8'(PULSE_CYC - 1)) begin
                        forming_writeread <= 1'b0;
                        we_writeread      <= 1'b0;
                        cnt               <= '0;
                        state             <= SETTLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == 8'(SETTLE_CYC - 1)) begin
                        re_writeread <= 1'b1;
                        cnt          <= '0;
                        state        <= VERIFY;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                VERIFY: begin
                    if (cnt == 8'(READ_CYC - 1)) begin
                        re_writeread <= 1'b0;
                        cap          <= arr_rdata;
                        cnt          <= '0;
                        state        <= CHECK;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (pass) begin
                        fail_q <= 1'b0;
                        state  <= FINISH;
                    end else if (pulse_cnt == 4'(MAX_PULSES)) begin
                        fail_q <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        v_code            <= (v_code == 4'hF) ? 4'hF : v_code + 4'd1;
                        pulse_cnt         <= pulse_cnt + 4'd1;
                        forming_writeread <= is_form;
                        we_writeread      <= !is_form;
                        state             <= PULSE;
                    end
                end
                READ: begin
                    if (cnt == 8'(READ_CYC - 1)) begin
                        re_writeread <= 1'b0;
                        rdata        <= arr_rdata;
                        fail_q       <= 1'b0;
                        cnt          <= '0;
                        state        <= FINISH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rram_verify_sequencer.sv
// Scoreboard bench for rram_verify_sequencer. Each request pushes its expected
// outcome, which comes from a small behavioural loop. A negedge monitor pops
// that outcome on done and compares status, latency and strobe activity.
module tb_rram_verify_sequencer;

    localparam int P = 4, S = 2, R = 2, MAXP = 8;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] op;
    logic [7:0] addr, wdata, arr_rdata;
    logic       forming_writeread, we_writeread, re_writeread;
    logic [7:0] arr_addr, arr_wdata, rdata;
    logic [3:0] v_code, pulse_cnt;
    logic       done, fail, RB;

    always #5 clk = ~clk;

    rram_verify_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .arr_rdata(arr_rdata), .forming_writeread(forming_writeread),
        .we_writeread(we_writeread), .re_writeread(re_writeread),
        .arr_addr(arr_addr), .arr_wdata(arr_wdata), .v_code(v_code),
        .pulse_cnt(pulse_cnt), .rdata(rdata), .done(done), .fail(fail), .RB(RB)
    );

    typedef struct {
        logic [7:0] rdata;
        logic [7:0] addr;
        logic       fail;
        logic [3:0] pcnt;
        logic [3:0] vcode;
        int         lat;
        int         t0;
        int         form_cyc;
        int         we_cyc;
        int         re_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, done_seen = 0;
    int   form_cyc = 0, we_cyc = 0, re_cyc = 0, form_pulses = 0;
    logic form_prev = 1'b0;

    // Array model: a constant word, or all ones once `need` forming pulses have landed.
    logic [7:0] arr_val = 8'h00;
    int         need = 0;
    assign arr_rdata = (need > 0 && form_pulses >= need) ? 8'hFF : arr_val;

    // Reference model of the persistent output registers.
    logic [3:0] m_pcnt = 0, m_vcode = 0;
    logic [7:0] m_rdata = 0, m_addr = 0;

    always @(posedge clk) cyc++;

    // Monitor: strobe exclusivity, activity counting and scoreboard pop on done.
    always @(negedge clk) begin
        if (rst) begin
            form_cyc = 0; we_cyc = 0; re_cyc = 0; form_pulses = 0; form_prev = 1'b0;
        end else begin
            n_chk++;
            if (int'(forming_writeread) + int'(we_writeread) + int'(re_writeread) > 1) begin
                n_fail++;
                $display("FAIL strobe_onehot: f=%b w=%b r=%b, required at most one high",
                         forming_writeread, we_writeread, re_writeread);
            end
            if (forming_writeread) form_cyc++;
            if (forming_writeread && !form_prev) form_pulses++;
            if (we_writeread) we_cyc++;
            if (re_writeread) re_cyc++;
            form_prev = forming_writeread;
            if (done) begin
                exp_t e;
                done_seen++;
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
                end else begin
                    e = sbq.pop_front();
                    n_chk += 8;
                    if (fail !== e.fail) begin n_fail++; $display("FAIL fail_flag: got %b exp %b", fail, e.fail); end
                    if (pulse_cnt !== e.pcnt) begin n_fail++; $display("FAIL pulse_cnt: got %0d exp %0d", pulse_cnt, e.pcnt); end
                    if (v_code !== e.vcode) begin n_fail++; $display("FAIL v_code: got %0d exp %0d", v_code, e.vcode); end
                    if (rdata !== e.rdata) begin n_fail++; $display("FAIL rdata: got %h exp %h", rdata, e.rdata); end
                    if (arr_addr !== e.addr) begin n_fail++; $display("FAIL arr_addr: got %h exp %h", arr_addr, e.addr); end
                    if (cyc - e.t0 - 1 != e.lat) begin n_fail++; $display("FAIL latency: got %0d exp %0d", cyc - e.t0 - 1, e.lat); end
                    if (RB !== 1'b0) begin n_fail++; $display("FAIL rb_at_done: got %b exp 0", RB); end
                    if (form_cyc != e.form_cyc || we_cyc != e.we_cyc || re_cyc != e.re_cyc) begin
                        n_fail++;
                        $display("FAIL strobe_cycles: got f/w/r %0d/%0d/%0d exp %0d/%0d/%0d",
                                 form_cyc, we_cyc, re_cyc, e.form_cyc, e.we_cyc, e.re_cyc);
                    end
                end
                form_cyc = 0; we_cyc = 0; re_cyc = 0; form_pulses = 0;
            end
        end
    end

    // Drive one request (caller sits just after a negedge) and push its expected result.
    task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] av, input int nd);
        exp_t       e;
        logic [3:0] vc;
        logic [7:0] data, word;
        int         n;
        bit         ok;
        e.form_cyc = 0; e.we_cyc = 0; e.re_cyc = 0; e.fail = 1'b0;
        if (o == 2'b10) begin
            e.lat = R + 1; e.re_cyc = R;
            m_rdata = av; m_addr = a;
        end else if (o == 2'b11) begin
            e.lat = 1; e.fail = 1'b1;
        end else begin
            vc = (o == 2'b00) ? 4'd8 : 4'd2;
            word = (o == 2'b00) ? 8'hFF : w;
            n = 0; ok = 0;
            while (!ok && n < MAXP) begin
                n++;
                if (n > 1) vc = (vc == 4'hF) ? vc : vc + 4'd1;
                data = (nd > 0 && n >= nd) ? 8'hFF : av;
                ok = (data == word);
            end
            e.fail = !ok;
            e.lat = n * (P + S + R + 1) + 1;
            if (o == 2'b00) e.form_cyc = n * P; else e.we_cyc = n * P;
            e.re_cyc = n * R;
            m_pcnt = 4'(n); m_vcode = vc; m_addr = a;
        end
        e.rdata = m_rdata; e.addr = m_addr; e.pcnt = m_pcnt; e.vcode = m_vcode;
        arr_val = av; need = nd;
        op = o; addr = a; wdata = w; start = 1'b1;
        e.t0 = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int k = 0;
        while (done_seen == d0 && k < budget) begin
            @(negedge clk); #1; k++;
        end
        n_chk++;
        if (done_seen == d0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; addr = 8'h00; wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk += 3;
        if ({forming_writeread, we_writeread, re_writeread} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b exp 000", {forming_writeread, we_writeread, re_writeread});
        end
        if ({done, fail, RB} !== 3'b001) begin
            n_fail++; $display("FAIL reset_status: got %b exp 001", {done, fail, RB});
        end
        if ({arr_addr, arr_wdata, rdata, pulse_cnt, v_code} !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h exp 0", {arr_addr, arr_wdata, rdata, pulse_cnt, v_code});
        end
        rst = 1'b0;
        m_pcnt = 0; m_vcode = 0; m_rdata = 0; m_addr = 0;
    endtask

    task automatic test_read();
        @(negedge clk);
        issue(2'b10, 8'h3C, 8'h00, 8'hA5, 0);
        @(negedge clk);
        n_chk++;
        if (re_writeread !== 1'b1) begin n_fail++; $display("FAIL read_strobe: got %b exp 1", re_writeread); end
        @(negedge clk);
        n_chk++;
        if (RB !== 1'b0) begin n_fail++; $display("FAIL read_busy: got %b exp 0", RB); end
        wait_done(20);
    endtask

    task automatic test_forming();
        @(negedge clk);
        issue(2'b00, 8'h11, 8'h00, 8'h00, 3);
        wait_done(100);
    endtask

    task automatic test_write_fail();
        @(negedge clk);
        issue(2'b01, 8'h22, 8'h5A, 8'h00, 0);
        @(negedge clk);
        n_chk++;
        if (arr_wdata !== 8'h5A) begin n_fail++; $display("FAIL write_data: got %h exp 5a", arr_wdata); end
        wait_done(200);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue(2'b01, 8'h33, 8'h5A, 8'h00, 0);
        @(negedge clk);
        n_chk++;
        if (we_writeread !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_strobe: got %b exp 1", we_writeread); end
        rst = 1'b1;
        @(negedge clk);
        n_chk += 2;
        if ({forming_writeread, we_writeread, re_writeread} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset_strobes: got %b exp 000", {forming_writeread, we_writeread, re_writeread});
        end
        if ({done, RB} !== 2'b01) begin
            n_fail++; $display("FAIL mid_reset_status: got done/RB %b exp 01", {done, RB});
        end
        sbq.delete();
        m_pcnt = 0; m_vcode = 0; m_rdata = 0; m_addr = 0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(2'b10, 8'h44, 8'h00, 8'hC3, 0);
        wait_done(20);
    endtask

    task automatic test_busy_and_reserved();
        @(negedge clk);
        issue(2'b00, 8'h55, 8'h00, 8'h00, 1);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b10; addr = 8'h99;
        @(negedge clk);
        start = 1'b0; addr = 8'h77;
        wait_done(50);
        @(negedge clk);
        issue(2'b11, 8'h66, 8'h00, 8'h00, 0);
        wait_done(10);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(2'b10, 8'h12, 8'h00, 8'h3C, 0);
        wait_done(20);
        issue(2'b10, 8'h34, 8'h00, 8'h96, 0);
        wait_done(20);
        issue(2'b01, 8'h56, 8'hC3, 8'hC3, 0);
        wait_done(40);
    endtask

    initial begin
        test_reset();
        test_read();
        test_forming();
        test_write_fail();
        test_reset_mid();
        test_busy_and_reserved();
        test_back_to_back();
        repeat (4) @(negedge clk);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++; $display("FAIL pending_ops: got %0d exp 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
